// File: rtl/ysyx_22050710_pkg.sv
// Shared definitions for the NPC core pipeline.
// - Datapath widths: XLEN, REGAW.
// - Operand select encodings used by the ID/EX stage.
// - ALU opcode constants, also used by the EXU ALU.
package ysyx_22050710_pkg;

    localparam int XLEN  = 64;
    localparam int REGAW = 5;

    // src_a select
    localparam logic [1:0] ASEL_RS1  = 2'd0;
    localparam logic [1:0] ASEL_PC   = 2'd1;
    localparam logic [1:0] ASEL_ZERO = 2'd2;

    // src_b select
    localparam logic [1:0] BSEL_RS2  = 2'd0;
    localparam logic [1:0] BSEL_IMM  = 2'd1;
    localparam logic [1:0] BSEL_FOUR = 2'd2;

    // ALU opcodes
    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_SLL   = 5'd2;
    localparam logic [4:0] ALU_SLT   = 5'd3;
    localparam logic [4:0] ALU_SLTU  = 5'd4;
    localparam logic [4:0] ALU_XOR   = 5'd5;
    localparam logic [4:0] ALU_SRL   = 5'd6;
    localparam logic [4:0] ALU_SRA   = 5'd7;
    localparam logic [4:0] ALU_OR    = 5'd8;
    localparam logic [4:0] ALU_AND   = 5'd9;
    localparam logic [4:0] ALU_COPYB = 5'd10;

endpackage

// File: rtl/ysyx_22050710_fwd_mux.sv
// Operand bypass mux for one source register (purely combinational).
// Ports:
//   i_addr/i_used/i_rf_data  source register address, read flag, regfile data
//   i_{ex,mem,wb}_{rd,we,result}  downstream bypass ports
//   o_data      forwarded operand (x0 always 0; EX > MEM > WB > regfile)
//   o_ex_match  source is read and EX is writing it (feeds load-use detect)
module ysyx_22050710_fwd_mux #(
    parameter int XLEN  = ysyx_22050710_pkg::XLEN,
    parameter int REGAW = ysyx_22050710_pkg::REGAW
) (
    input  logic [REGAW-1:0] i_addr,
    input  logic             i_used,
    input  logic [XLEN-1:0]  i_rf_data,
    input  logic [REGAW-1:0] i_ex_rd,
    input  logic             i_ex_we,
    input  logic [XLEN-1:0]  i_ex_result,
    input  logic [REGAW-1:0] i_mem_rd,
    input  logic             i_mem_we,
    input  logic [XLEN-1:0]  i_mem_result,
    input  logic [REGAW-1:0] i_wb_rd,
    input  logic             i_wb_we,
    input  logic [XLEN-1:0]  i_wb_result,
    output logic [XLEN-1:0]  o_data,
    output logic             o_ex_match
);
    import ysyx_22050710_pkg::*;

    logic nz, ex_hit, mem_hit, wb_hit;

    // A bypass only counts for a nonzero address, so writes to x0 never leak.
    assign nz      = (i_addr != '0);
    assign ex_hit  = nz & i_ex_we  & (i_ex_rd  == i_addr);
    assign mem_hit = nz & i_mem_we & (i_mem_rd == i_addr);
    assign wb_hit  = nz & i_wb_we  & (i_wb_rd  == i_addr);

    assign o_ex_match = i_used & ex_hit;

    always_comb begin
        o_data = i_rf_data;
        if (!nz)         o_data = '0;
        else if (ex_hit)  o_data = i_ex_result;
        else if (mem_hit) o_data = i_mem_result;
        else if (wb_hit)  o_data = i_wb_result;
    end

endmodule

// File: rtl/ysyx_22050710_idex_stage.sv
// ID/EX pipeline register of the NPC core.
// Accepts decoded instructions from the IDU (i_in_valid/o_in_ready), resolves
// RAW hazards by bypassing from EX/MEM/WB, stalls on load-use, and registers
// the final ALU operands so the ALU is driven directly from flops.
// Ports:
//   i_clk, i_rst_n              clock, async active-low reset
//   i_in_valid/o_in_ready       upstream handshake
//   i_* decode fields            pc, sources, imm, selects, ALU op, rd, load
//   i_{ex,mem,wb}_*              bypass ports and EX load flag
//   i_flush                      kill held and incoming instruction
//   o_out_valid/i_out_ready      downstream handshake
//   o_* payload                  ALU operands, op, pc, store data, rd, load
module ysyx_22050710_idex_stage #(
    parameter int XLEN  = ysyx_22050710_pkg::XLEN,
    parameter int REGAW = ysyx_22050710_pkg::REGAW
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [XLEN-1:0]  i_pc,
    input  logic [REGAW-1:0] i_rs1_addr,
    input  logic [REGAW-1:0] i_rs2_addr,
    input  logic             i_rs1_used,
    input  logic             i_rs2_used,
    input  logic [XLEN-1:0]  i_rs1_data,
    input  logic [XLEN-1:0]  i_rs2_data,
    input  logic [XLEN-1:0]  i_imm,
    input  logic [1:0]       i_asel,
    input  logic [1:0]       i_bsel,
    input  logic [4:0]       i_ALUctr,
    input  logic             i_word_cut,
    input  logic [REGAW-1:0] i_rd_addr,
    input  logic             i_rd_we,
    input  logic             i_is_load,
    input  logic [REGAW-1:0] i_ex_rd,
    input  logic [REGAW-1:0] i_mem_rd,
    input  logic [REGAW-1:0] i_wb_rd,
    input  logic             i_ex_we,
    input  logic             i_mem_we,
    input  logic             i_wb_we,
    input  logic             i_ex_is_load,
    input  logic [XLEN-1:0]  i_ex_result,
    input  logic [XLEN-1:0]  i_mem_result,
    input  logic [XLEN-1:0]  i_wb_result,
    input  logic             i_flush,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [XLEN-1:0]  o_src_a,
    output logic [XLEN-1:0]  o_src_b,
    output logic [4:0]       o_ALUctr,
    output logic             o_word_cut,
    output logic [XLEN-1:0]  o_pc,
    output logic [XLEN-1:0]  o_store_data,
    output logic [REGAW-1:0] o_rd_addr,
    output logic             o_rd_we,
    output logic             o_is_load
);
    import ysyx_22050710_pkg::*;

    logic [XLEN-1:0] rs1_fwd, rs2_fwd, src_a_nxt, src_b_nxt;
    logic            rs1_ex_match, rs2_ex_match;
    logic            hazard, capture, fire;

    ysyx_22050710_fwd_mux #(.XLEN(XLEN), .REGAW(REGAW)) u_fwd_rs1 (
        .i_addr(i_rs1_addr), .i_used(i_rs1_used), .i_rf_data(i_rs1_data),
        .i_ex_rd(i_ex_rd),   .i_ex_we(i_ex_we),   .i_ex_result(i_ex_result),
        .i_mem_rd(i_mem_rd), .i_mem_we(i_mem_we), .i_mem_result(i_mem_result),
        .i_wb_rd(i_wb_rd),   .i_wb_we(i_wb_we),   .i_wb_result(i_wb_result),
        .o_data(rs1_fwd),    .o_ex_match(rs1_ex_match)
    );

    ysyx_22050710_fwd_mux #(.XLEN(XLEN), .REGAW(REGAW)) u_fwd_rs2 (
        .i_addr(i_rs2_addr), .i_used(i_rs2_used), .i_rf_data(i_rs2_data),
        .i_ex_rd(i_ex_rd),   .i_ex_we(i_ex_we),   .i_ex_result(i_ex_result),
        .i_mem_rd(i_mem_rd), .i_mem_we(i_mem_we), .i_mem_result(i_mem_result),
        .i_wb_rd(i_wb_rd),   .i_wb_we(i_wb_we),   .i_wb_result(i_wb_result),
        .o_data(rs2_fwd),    .o_ex_match(rs2_ex_match)
    );

    // Load data is not available until MEM, so a used source that matches
    // a load in EX must wait one cycle. ex_match already excludes x0.
    assign hazard     = i_ex_is_load & (rs1_ex_match | rs2_ex_match);
    assign o_in_ready = (~o_out_valid | i_out_ready) & ~hazard & ~i_flush;
    assign capture    = i_in_valid & o_in_ready;
    assign fire       = o_out_valid & i_out_ready;

    always_comb begin
        src_a_nxt = '0;
        case (i_asel)
            ASEL_RS1: src_a_nxt = rs1_fwd;
            ASEL_PC:  src_a_nxt = i_pc;
            default:  src_a_nxt = '0;   // ASEL_ZERO and unused code 3
        endcase
    end

    always_comb begin
        src_b_nxt = '0;
        case (i_bsel)
            BSEL_RS2:  src_b_nxt = rs2_fwd;
            BSEL_IMM:  src_b_nxt = i_imm;
            BSEL_FOUR: src_b_nxt = XLEN'(4);
            default:   src_b_nxt = '0;
        endcase
    end

    // Flush beats capture; a drain with no capture writes a bubble. Bubbles
    // clear rd_we/is_load so nothing downstream sees a stale side effect.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_out_valid  <= 1'b0;
            o_src_a      <= '0;
            o_src_b      <= '0;
            o_ALUctr     <= '0;
            o_word_cut   <= 1'b0;
            o_pc         <= '0;
            o_store_data <= '0;
            o_rd_addr    <= '0;
            o_rd_we      <= 1'b0;
            o_is_load    <= 1'b0;
        end else if (i_flush) begin
            o_out_valid <= 1'b0;
            o_rd_we     <= 1'b0;
            o_is_load   <= 1'b0;
        end else if (capture) begin
            o_out_valid  <= 1'b1;
            o_src_a      <= src_a_nxt;
            o_src_b      <= src_b_nxt;
            o_ALUctr     <= i_ALUctr;
            o_word_cut   <= i_word_cut;
            o_pc         <= i_pc;
            o_store_data <= rs2_fwd;
            o_rd_addr    <= i_rd_addr;
            o_rd_we      <= i_rd_we;
            o_is_load    <= i_is_load;
        end else if (fire) begin
            o_out_valid <= 1'b0;
            o_rd_we     <= 1'b0;
            o_is_load   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ysyx_22050710_idex_stage.sv
module tb_ysyx_22050710_idex_stage;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_in_valid, o_in_ready;
    logic [63:0] i_pc, i_rs1_data, i_rs2_data, i_imm;
    logic [4:0]  i_rs1_addr, i_rs2_addr;
    logic        i_rs1_used, i_rs2_used;
    logic [1:0]  i_asel, i_bsel;
    logic [4:0]  i_ALUctr;
    logic        i_word_cut;
    logic [4:0]  i_rd_addr;
    logic        i_rd_we, i_is_load;
    logic [4:0]  i_ex_rd, i_mem_rd, i_wb_rd;
    logic        i_ex_we, i_mem_we, i_wb_we, i_ex_is_load;
    logic [63:0] i_ex_result, i_mem_result, i_wb_result;
    logic        i_flush;
    logic        o_out_valid, i_out_ready;
    logic [63:0] o_src_a, o_src_b, o_pc, o_store_data;
    logic [4:0]  o_ALUctr;
    logic        o_word_cut;
    logic [4:0]  o_rd_addr;
    logic        o_rd_we, o_is_load;

    int n_chk = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    ysyx_22050710_idex_stage dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_pc(i_pc), .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
        .i_rs1_used(i_rs1_used), .i_rs2_used(i_rs2_used),
        .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm(i_imm),
        .i_asel(i_asel), .i_bsel(i_bsel), .i_ALUctr(i_ALUctr),
        .i_word_cut(i_word_cut), .i_rd_addr(i_rd_addr), .i_rd_we(i_rd_we),
        .i_is_load(i_is_load),
        .i_ex_rd(i_ex_rd), .i_mem_rd(i_mem_rd), .i_wb_rd(i_wb_rd),
        .i_ex_we(i_ex_we), .i_mem_we(i_mem_we), .i_wb_we(i_wb_we),
        .i_ex_is_load(i_ex_is_load),
        .i_ex_result(i_ex_result), .i_mem_result(i_mem_result),
        .i_wb_result(i_wb_result), .i_flush(i_flush),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_src_a(o_src_a), .o_src_b(o_src_b), .o_ALUctr(o_ALUctr),
        .o_word_cut(o_word_cut), .o_pc(o_pc), .o_store_data(o_store_data),
        .o_rd_addr(o_rd_addr), .o_rd_we(o_rd_we), .o_is_load(o_is_load)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_in_valid = 0; i_pc = '0; i_rs1_addr = '0; i_rs2_addr = '0;
        i_rs1_used = 0; i_rs2_used = 0; i_rs1_data = '0; i_rs2_data = '0;
        i_imm = '0; i_asel = 0; i_bsel = 0; i_ALUctr = '0; i_word_cut = 0;
        i_rd_addr = '0; i_rd_we = 0; i_is_load = 0;
        i_ex_rd = '0; i_mem_rd = '0; i_wb_rd = '0;
        i_ex_we = 0; i_mem_we = 0; i_wb_we = 0; i_ex_is_load = 0;
        i_ex_result = '0; i_mem_result = '0; i_wb_result = '0;
        i_flush = 0; i_out_ready = 1;
    endtask

    initial begin
        idle();
        i_rst_n = 0;
        #12;
        chk("rst_valid", o_out_valid, 0);
        chk("rst_rd_we", o_rd_we, 0);
        chk("rst_is_load", o_is_load, 0);
        chk("rst_src_a", o_src_a, 0);
        chk("rst_in_ready", o_in_ready, 1);
        i_rst_n = 1;
        step();

        // EX forwarding wins over MEM for rs1
        i_in_valid = 1; i_pc = 64'h8000_0000;
        i_rs1_addr = 5; i_rs1_used = 1; i_rs1_data = 64'h1111;
        i_ex_rd = 5; i_ex_we = 1; i_ex_result = 64'h1234;
        i_mem_rd = 5; i_mem_we = 1; i_mem_result = 64'h9999;
        i_asel = 0; i_bsel = 1; i_imm = 64'h10;
        i_ALUctr = 5'd3; i_word_cut = 1; i_rd_addr = 9; i_rd_we = 1;
        #1 chk("fwd_ex_ready", o_in_ready, 1);
        step();
        chk("fwd_ex_valid", o_out_valid, 1);
        chk("fwd_ex_src_a", o_src_a, 64'h1234);
        chk("fwd_ex_src_b_imm", o_src_b, 64'h10);
        chk("fwd_ex_aluctr", o_ALUctr, 3);
        chk("fwd_ex_word_cut", o_word_cut, 1);
        chk("fwd_ex_pc", o_pc, 64'h8000_0000);
        chk("fwd_ex_rd", o_rd_addr, 9);
        chk("fwd_ex_rd_we", o_rd_we, 1);

        // x0 guard, bsel=FOUR, rs2 forwarded from WB into store data
        idle();
        i_in_valid = 1; i_pc = 64'h100;
        i_rs1_addr = 0; i_rs1_used = 1; i_rs1_data = 64'h5555;
        i_ex_rd = 0; i_ex_we = 1; i_ex_result = 64'hFFFF;
        i_rs2_addr = 3; i_rs2_used = 1; i_rs2_data = 64'hABCD;
        i_wb_rd = 3; i_wb_we = 1; i_wb_result = 64'h7777;
        i_asel = 0; i_bsel = 2; i_rd_addr = 1; i_rd_we = 1;
        step();
        chk("x0_src_a", o_src_a, 0);
        chk("bsel_four", o_src_b, 4);
        chk("wb_store_data", o_store_data, 64'h7777);

        // Load-use on rs2: not a hazard while rs2 is unused
        idle();
        i_in_valid = 1; i_pc = 64'h104;
        i_rs1_addr = 1; i_rs1_used = 0; i_rs1_data = 64'h22;
        i_rs2_addr = 7; i_rs2_used = 0; i_rs2_data = 64'h1;
        i_ex_rd = 7; i_ex_we = 1; i_ex_is_load = 1; i_ex_result = 64'hBAD;
        i_rd_addr = 8; i_rd_we = 1;
        #1 chk("lu_unused_ready", o_in_ready, 1);
        i_rs2_used = 1;
        #1 chk("lu_hazard_ready", o_in_ready, 0);
        step();
        chk("lu_bubble_valid", o_out_valid, 0);
        chk("lu_bubble_rd_we", o_rd_we, 0);
        // load now in MEM
        i_ex_rd = 0; i_ex_we = 0; i_ex_is_load = 0;
        i_mem_rd = 7; i_mem_we = 1; i_mem_result = 64'hDEAD;
        #1 chk("lu_after_ready", o_in_ready, 1);
        step();
        chk("lu_cap_valid", o_out_valid, 1);
        chk("lu_cap_src_b", o_src_b, 64'hDEAD);
        chk("lu_cap_store", o_store_data, 64'hDEAD);
        chk("lu_cap_src_a", o_src_a, 64'h22);
        chk("lu_cap_rd", o_rd_addr, 8);

        // Backpressure for 3 cycles, then fire+capture in one cycle
        idle();
        i_out_ready = 0;
        i_in_valid = 1; i_pc = 64'h200; i_asel = 1; i_bsel = 1; i_imm = 64'h8;
        i_rs2_addr = 2; i_rs2_data = 64'h4444;
        i_rd_addr = 12; i_rd_we = 1; i_is_load = 1;
        for (int k = 0; k < 3; k++) begin
            #1 chk("bp_ready", o_in_ready, 0);
            step();
            chk("bp_valid", o_out_valid, 1);
            chk("bp_src_b", o_src_b, 64'hDEAD);
            chk("bp_pc", o_pc, 64'h104);
        end
        i_out_ready = 1;
        #1 chk("bp_release_ready", o_in_ready, 1);
        step();
        chk("bp_cap_valid", o_out_valid, 1);
        chk("bp_cap_src_a", o_src_a, 64'h200);
        chk("bp_cap_src_b", o_src_b, 64'h8);
        chk("bp_cap_load", o_is_load, 1);
        chk("bp_cap_rd", o_rd_addr, 12);
        chk("bp_cap_store", o_store_data, 64'h4444);

        // Flush with a valid incoming instruction and a hazard, EX stalled
        idle();
        i_out_ready = 0; i_flush = 1;
        i_in_valid = 1; i_pc = 64'h300;
        i_rs1_addr = 4; i_rs1_used = 1;
        i_ex_rd = 4; i_ex_we = 1; i_ex_is_load = 1;
        i_rd_addr = 13; i_rd_we = 1;
        #1 chk("flush_ready", o_in_ready, 0);
        step();
        chk("flush_valid", o_out_valid, 0);
        chk("flush_rd_we", o_rd_we, 0);
        chk("flush_is_load", o_is_load, 0);
        chk("flush_pc_kept", o_pc, 64'h200);

        // Invalid select code 3 gives zero on both operands
        idle();
        i_in_valid = 1; i_pc = 64'h400; i_asel = 3; i_bsel = 3;
        i_rs1_addr = 6; i_rs1_data = 64'h66; i_rs2_addr = 6; i_rs2_data = 64'h66;
        i_imm = 64'h77; i_rd_addr = 14; i_rd_we = 1;
        step();
        chk("sel3_valid", o_out_valid, 1);
        chk("sel3_src_a", o_src_a, 0);
        chk("sel3_src_b", o_src_b, 0);

        // Asynchronous reset while valid
        idle();
        i_out_ready = 0;
        #2 i_rst_n = 0;
        #1;
        chk("arst_valid", o_out_valid, 0);
        chk("arst_rd_we", o_rd_we, 0);
        chk("arst_pc", o_pc, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ysyx_22050710_idex_stage.md
Name: ysyx_22050710_idex_stage

Overview:
- ID/EX pipeline stage of the NPC core; it sits directly upstream of the EXU ALU.
- Captures decoded instructions from the IDU through a valid/ready handshake.
- Resolves RAW hazards by forwarding from EX, MEM and WB, and detects load-use hazards.
- Registers the fully selected ALU operands (src_a, src_b, ALUctr, word_cut) so the ALU is fed straight from flops.

Parameters:
- XLEN, 64, datapath width.
- REGAW, 5, register address width.

Ports:
- i_clk  in  1  single clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_in_valid  in  1  IDU has an instruction.
- o_in_ready  out  1  stage accepts it this cycle.
- i_pc  in  XLEN  instruction PC.
- i_rs1_addr, i_rs2_addr  in  REGAW  source registers.
- i_rs1_used, i_rs2_used  in  1  source is actually read.
- i_rs1_data, i_rs2_data  in  XLEN  regfile read data.
- i_imm  in  XLEN  sign-extended immediate.
- i_asel  in  2  src_a select: 0=rs1, 1=pc, 2=zero.
- i_bsel  in  2  src_b select: 0=rs2, 1=imm, 2=constant 4.
- i_ALUctr  in  5  ALU opcode, passed through.
- i_word_cut  in  1  W-type op, passed through.
- i_rd_addr  in  REGAW  destination register.
- i_rd_we  in  1  destination write enable.
- i_is_load  in  1  instruction is a load.
- i_ex_rd, i_mem_rd, i_wb_rd  in  REGAW  downstream destinations.
- i_ex_we, i_mem_we, i_wb_we  in  1  downstream write enables (already qualified by stage valid).
- i_ex_is_load  in  1  instruction in EX is a load.
- i_ex_result, i_mem_result, i_wb_result  in  XLEN  forwardable values.
- i_flush  in  1  kill the held and incoming instruction.
- o_out_valid  out  1  EX holds a valid instruction.
- i_out_ready  in  1  EX consumes it.
- o_src_a, o_src_b  out  XLEN  ALU operands.
- o_ALUctr  out  5  ALU opcode.
- o_word_cut  out  1  W-type op.
- o_pc  out  XLEN  PC.
- o_store_data  out  XLEN  forwarded rs2 value, for stores.
- o_rd_addr  out  REGAW  destination register.
- o_rd_we  out  1  destination write enable.
- o_is_load  out  1  instruction is a load.

Behaviour:
- Reset, asynchronous on i_rst_n low: every output register is 0. This includes o_out_valid, o_rd_we and o_is_load.
- Forwarding is evaluated combinationally on the capture side, independently for each source.
  - Priority: EX > MEM > WB > regfile.
  - A source matches only when its we=1, its rd equals the source address, and rd != 0.
  - x0 always reads 0.
- Load-use hazard: hazard=1 when all of the following hold:
  - i_ex_is_load and i_ex_we are set and i_ex_rd != 0;
  - i_ex_rd matches a used source (rs1 with i_rs1_used, or rs2 with i_rs2_used).
- Ready: o_in_ready = (~o_out_valid | i_out_ready) & ~hazard & ~i_flush.
- Capture: when i_in_valid & o_in_ready, on the next edge:
  - all output registers load;
  - o_src_a/o_src_b take the asel/bsel result from the forwarded operands;
  - o_store_data takes the forwarded rs2;
  - o_out_valid=1.
- Drain: output fires when o_out_valid & i_out_ready. If it fires with no capture in the same cycle, o_out_valid goes to 0 on the next edge (a bubble is inserted during a hazard).
- Hold: when o_out_valid & ~i_out_ready, all outputs stay stable and o_in_ready=0.
- Flush: i_flush=1 means o_out_valid=0 on the next edge regardless of the handshake, and the incoming instruction is dropped. Flush overrides capture and hazard.
- Payload registers are don't-care while o_out_valid=0, except o_rd_we and o_is_load: these are forced to 0 whenever a bubble or flush is written.
- Simultaneous fire and capture: full throughput, one instruction per cycle with no bubble.
- Invalid asel/bsel code 3 selects zero.
- Latency: exactly one cycle from capture to o_out_valid.

Decomposition:
- Shared package (ysyx_22050710_pkg):
  - ASEL_RS1/PC/ZERO and BSEL_RS2/IMM/FOUR encodings;
  - ALUctr opcode constants shared with the ALU;
  - XLEN and REGAW.
- One natural sub-module, ysyx_22050710_fwd_mux: purely combinational. It takes addr, used, regfile data and the three bypass ports, and returns the forwarded value plus a match flag. It is instantiated twice (rs1, rs2).

Test Plan:
1. Reset mid-stream: i_rst_n=0 asynchronously while o_out_valid=1 -> o_out_valid=0, o_rd_we=0 before the next edge.
2. EX forwarding: rs1=5, i_ex_rd=5, i_ex_we=1, i_ex_result=0x1234, i_mem_rd=5 with 0x9999, asel=0 -> o_src_a=0x1234 next cycle.
3. Load-use: i_ex_is_load=1, i_ex_rd=7, incoming rs2=7 used -> o_in_ready=0. The next edge yields o_out_valid=0 (bubble) when i_out_ready=1. The cycle after the load leaves EX, the instruction is captured with the MEM-forwarded value.
4. x0 guard: rs1=0, i_ex_rd=0, i_ex_we=1, i_ex_result=0xFFFF -> o_src_a=0.
5. Backpressure: i_out_ready=0 for 3 cycles with i_in_valid=1 -> outputs stable and o_in_ready=0. Then i_out_ready=1 -> fire and capture in the same cycle, with no bubble.
6. Flush priority: i_flush=1 together with a valid capture and hazard -> o_out_valid=0 next cycle and no instruction captured. Operand select check: bsel=2 yields o_src_b=4.
